data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 154 +++++++++++++++
 tb/tb_data_mem_responder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Purpose: multi-cycle data memory for the pipeline MEM stage. A load or
// store request is accepted in IDLE, held for LATENCY wait cycles in BUSY,
// and performed on entry into a one-cycle DONE state. MemStall freezes the
// pipeline from the request cycle until DONE. Misaligned, out-of-range and
// read/write-conflicting accesses raise a one-cycle MemError in DONE.
//
// Parameters:
//   DEPTH    number of 32-bit words stored (1..1024)
//   LATENCY  wait cycles between acceptance and completion (0..15)
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset (also clears the storage)
//   MemRead    load request, level, held while MemStall=1
//   MemWrite   store request, level, held while MemStall=1
//   Address    byte address, word index = Address[31:2]
//   WriteData  store data, sampled at acceptance
//   ReadData   registered load data
//   MemStall   combinational pipeline freeze
//   MemError   registered one-cycle error pulse in DONE
// ----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        MemStall,
    output logic        MemError
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WCNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  wcnt_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem_q [DEPTH];

    logic             req;
    logic             acc_rd;
    logic             acc_wr;
    logic [31:0]      acc_addr;
    logic [31:0]      acc_wdata;
    logic [IDX_W-1:0] acc_idx;
    logic             enter_done;
    logic             bad_addr;
    logic             conflict;
    logic             do_write;

    always_comb begin
        req      = MemRead | MemWrite;
        MemStall = !rst && (((state_q == IDLE) && req) || (state_q == BUSY));

        // With LATENCY=0 the access completes on the acceptance edge, so the
        // live inputs are used; otherwise the values latched at acceptance.
        if (state_q == IDLE) begin
            acc_rd    = MemRead;
            acc_wr    = MemWrite;
            acc_addr  = Address;
            acc_wdata = WriteData;
        end else begin
            acc_rd    = rd_q;
            acc_wr    = wr_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
        end

        enter_done = ((state_q == IDLE) && req && (LATENCY == 0)) ||
                     ((state_q == BUSY) && (wcnt_q == 4'd0));
        acc_idx    = acc_addr[IDX_W+1:2];
        bad_addr   = (acc_addr[1:0] != 2'b00) ||
                     ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
        // Read+write together executes as a write, but is still flagged.
        conflict   = acc_rd & acc_wr;
        do_write   = enter_done && acc_wr && !bad_addr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wcnt_q  <= 4'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        rd_q    <= MemRead;
                        wr_q    <= MemWrite;
                        addr_q  <= Address;
                        wdata_q <= WriteData;
                        wcnt_q  <= WCNT_INIT;
                        state_q <= (LATENCY == 0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    if (wcnt_q == 4'd0) begin
                        state_q <= DONE;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            if (enter_done) begin
                err_q <= bad_addr | conflict;
                // Writes (including conflicting ones) leave ReadData alone.
                if (!acc_wr) begin
                    rdata_q <= bad_addr ? 32'd0 : mem_q[acc_idx];
                end
            end
        end
    end

    // Storage: cleared by reset, so an aborted write can never land.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else if (do_write) begin
            mem_q[acc_idx] <= acc_wdata;
        end
    end

    assign ReadData = rdata_q;
    assign MemError = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. One instance uses the default
// LATENCY=2 / DEPTH=256, a second uses LATENCY=0. Expected values are
// hand-computed constants in the stimulus list.
// ----------------------------------------------------------------------------
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemStall;
    logic        MemError;

    logic        rd0;
    logic        wr0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic [31:0] rdata0;
    logic        stall0;
    logic        err0;

    int n_chk  = 0;
    int n_pass = 0;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .MemStall  (MemStall),
        .MemError  (MemError)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .MemRead   (rd0),
        .MemWrite  (wr0),
        .Address   (addr0),
        .WriteData (wdata0),
        .ReadData  (rdata0),
        .MemStall  (stall0),
        .MemError  (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // One transaction on the LATENCY=2 instance. Called just after a rising
    // edge; returns at the falling edge of the DONE cycle (keep=1, inputs
    // still asserted) or of the following idle cycle (keep=0).
    task automatic xact(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input bit drop, input bit keep);
        int stalls;
        int early;
        stalls    = 0;
        early     = 0;
        MemRead   = rd;
        MemWrite  = wr;
        Address   = addr;
        WriteData = wdata;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!MemStall) break;
            stalls++;
            if (MemError) early++;
            @(posedge clk);
            #1;
            if (drop) begin
                MemRead  = 1'b0;
                MemWrite = 1'b0;
            end
        end
        chk({tag, " stall cycles"}, 32'(stalls), 32'd3);
        chk({tag, " err while stalled"}, 32'(early), 32'd0);
        chk({tag, " done err"}, {31'd0, MemError}, {31'd0, exp_err});
        chk({tag, " done rdata"}, ReadData, exp_rd);
        if (!keep) begin
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            @(negedge clk);
            chk({tag, " idle stall"}, {31'd0, MemStall}, 32'd0);
            chk({tag, " idle err"}, {31'd0, MemError}, 32'd0);
            chk({tag, " idle rdata"}, ReadData, exp_rd);
        end
    endtask

    // One transaction on the LATENCY=0 instance, called just after a rising edge.
    task automatic xact0(input string tag, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd);
        rd0    = rd;
        wr0    = wr;
        addr0  = addr;
        wdata0 = wdata;
        @(negedge clk);
        chk({tag, " stall"}, {31'd0, stall0}, 32'd1);
        edge1();
        rd0 = 1'b0;
        wr0 = 1'b0;
        @(negedge clk);
        chk({tag, " done stall"}, {31'd0, stall0}, 32'd0);
        chk({tag, " done err"}, {31'd0, err0}, 32'd0);
        chk({tag, " done rdata"}, rdata0, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        Address   = 32'h10;
        WriteData = 32'd0;
        rd0       = 1'b1;
        wr0       = 1'b0;
        addr0     = 32'd0;
        wdata0    = 32'd0;

        // Reset with requests asserted: no stall, outputs cleared.
        @(negedge clk);
        chk("rst stall", {31'd0, MemStall}, 32'd0);
        chk("rst stall0", {31'd0, stall0}, 32'd0);
        chk("rst rdata", ReadData, 32'd0);
        chk("rst err", {31'd0, MemError}, 32'd0);

        // First request in the first cycle after reset.
        edge1();
        rst = 1'b0;
        rd0 = 1'b0;
        xact("wr 10", 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1'b0);
        edge1(); xact("rd 10", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        edge1(); xact("rd 13 misalign", 1'b1, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
        edge1(); xact("rd 10 again", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
        edge1(); xact("rd 400 range", 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
        edge1(); xact("rdwr 8 conflict", 1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 1'b1, 32'h0, 1'b0, 1'b0);
        edge1(); xact("rd 8", 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0);
        edge1(); xact("wr 4 dropped", 1'b0, 1'b1, 32'h4, 32'hCAFEF00D, 1'b0, 32'h5A5A5A5A, 1'b1, 1'b0);
        edge1(); xact("rd 4", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);
        edge1(); xact("rd 3fc last", 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        // Back-to-back: read accepted in the cycle right after the write's DONE.
        edge1(); xact("wr 30 b2b", 1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, 1'b1);
        edge1(); xact("rd 30 b2b", 1'b1, 1'b0, 32'h30, 32'h0, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b0);

        // Reset in the second BUSY cycle of a write aborts it.
        edge1();
        MemWrite  = 1'b1;
        Address   = 32'h20;
        WriteData = 32'h12345678;
        @(negedge clk);
        chk("abort req stall", {31'd0, MemStall}, 32'd1);
        edge1();
        @(negedge clk);
        chk("abort busy1 stall", {31'd0, MemStall}, 32'd1);
        edge1();
        rst = 1'b1;
        @(negedge clk);
        chk("abort rst stall", {31'd0, MemStall}, 32'd0);
        edge1();
        rst      = 1'b0;
        MemWrite = 1'b0;
        @(negedge clk);
        chk("abort post stall", {31'd0, MemStall}, 32'd0);
        chk("abort post err", {31'd0, MemError}, 32'd0);
        chk("abort post rdata", ReadData, 32'd0);
        edge1(); xact("rd 20 aborted", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        edge1(); xact("rd 4 cleared", 1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // Errored writes must not touch storage.
        edge1(); xact("wr 20", 1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, 32'h0, 1'b0, 1'b0);
        edge1(); xact("wr 22 misalign", 1'b0, 1'b1, 32'h22, 32'h99999999, 1'b1, 32'h0, 1'b0, 1'b0);
        edge1(); xact("rd 20 kept", 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h11111111, 1'b0, 1'b0);
        edge1(); xact("wr 400 range", 1'b0, 1'b1, 32'h400, 32'h77777777, 1'b1, 32'h11111111, 1'b0, 1'b0);
        edge1(); xact("rd 0 untouched", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

        // LATENCY=0 instance.
        edge1(); xact0("L0 rd 0", 1'b1, 1'b0, 32'h0, 32'h0, 32'h0);
        edge1(); xact0("L0 wr 4", 1'b0, 1'b1, 32'h4, 32'h13579BDF, 32'h0);
        edge1(); xact0("L0 rd 4", 1'b1, 1'b0, 32'h4, 32'h0, 32'h13579BDF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
